treasure_vote_ctrl: RTL and testbench
=====================================

Name: treasure_vote_ctrl

Overview:
- Frame-level controller between the camera image processor and the Arduino link.
- On an Arduino request, it skips settling frames, then collects the processor's 3-bit treasure code once per VGA frame and majority-votes over a fixed window.
- It then presents the winning code to the Arduino over a REQ/VALID/ACK handshake with timeout.
- It replaces the Arduino directly polling an unfiltered RESULT.

Parameters:
- NUM_FRAMES, 8: frames per vote window; legal range 1..15.
- CONF_MIN, 5: minimum votes the winning code needs, else 3'b000 is reported.
- WARMUP_FRAMES, 4: frames discarded after a request before collecting; 0 allowed.
- TIMEOUT_CYC, 25000: CLK cycles to wait for ACK in PRESENT; 16-bit counter.

Ports:
- CLK  in  1  system clock (25 MHz VGA/processor clock)
- RESET_N  in  1  asynchronous active-low reset
- VGA_VSYNC_NEG  in  1  VGA vsync, same signal the image processor uses
- RESULT_IN  in  3  treasure code from the image processor (000 none, 001..110 shape/colour codes, 111 unused)
- ARD_REQ  in  1  Arduino request level (asynchronous; 2-flop synchronized)
- ARD_ACK  in  1  Arduino acknowledge level (asynchronous; 2-flop synchronized)
- RESULT_OUT  out  3  voted code, stable while RESULT_VALID=1
- RESULT_VALID  out  1  result presented
- BUSY  out  1  high in every state except IDLE
- TIMEOUT  out  1  sticky: last handshake timed out

Behaviour:
- Reset (async assert, sync release):
  - State=IDLE.
  - RESULT_OUT=000, RESULT_VALID=0, BUSY=0, TIMEOUT=0.
  - All histogram, frame and timeout counters=0.
  - Sync and edge registers=0.
- Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- Frame tick: one-cycle pulse when registered VGA_VSYNC_NEG goes 1->0. RESULT_IN is sampled on the cycle after the tick, because the processor updates RESULT on that same edge.
- Request event: rising edge of synchronized ARD_REQ. It is accepted only in IDLE and ignored in all other states.
- States:
  - IDLE: BUSY=0. On request event: clear histogram and frame counter, clear TIMEOUT, go WARMUP (or COLLECT if WARMUP_FRAMES=0).
  - WARMUP: count frame ticks. After WARMUP_FRAMES ticks, go COLLECT.
  - COLLECT: on each sample cycle, increment hist[RESULT_IN] (8 counters x 4 bits; cannot saturate since NUM_FRAMES<=15) and the frame counter. When the frame counter reaches NUM_FRAMES, go DECIDE.
  - DECIDE (exactly 1 cycle):
    - Winner = code with maximum count; ties go to the lowest code value.
    - If the winner's count < CONF_MIN, the winner is 000.
    - Register the winner into RESULT_OUT, then go PRESENT.
  - PRESENT:
    - RESULT_VALID=1; RESULT_OUT frozen.
    - Timeout counter increments every cycle.
    - Synchronized ARD_ACK=1: go RELEASE.
    - Counter reaches TIMEOUT_CYC-1 first: set TIMEOUT=1, RESULT_VALID=0, go IDLE.
  - RELEASE: RESULT_VALID=0. Wait for synchronized ARD_ACK=0 and synchronized ARD_REQ=0, then go IDLE.
- Abort: ARD_REQ deasserted (synchronized) during WARMUP or COLLECT returns to IDLE next cycle. Counters are cleared, RESULT_OUT is unchanged, and RESULT_VALID stays 0.
- Simultaneous ACK and timeout expiry in the same cycle: ACK wins and TIMEOUT is not set.
- Latency, last frame tick to RESULT_VALID=1: 1 sample cycle + 1 DECIDE + 1 register = 3 cycles.
- RESULT_OUT holds its last value in IDLE.
- RESULT_IN=111 is counted like any other code.

Optional Feature:
- Macro FAST_REPLY_EN.
- When defined:
  - In IDLE the block runs vote windows continuously in the background (no warmup between back-to-back windows; one warmup after reset).
  - Each completed window updates an internal last_vote register and sets have_vote.
  - A request event with have_vote=1 goes straight to PRESENT on the next cycle, with RESULT_OUT=last_vote.
  - A request event with have_vote=0 follows the normal path.
  - The background window restarts after RELEASE/timeout.
- When not defined: no background collection, and every request pays WARMUP_FRAMES+NUM_FRAMES frames.

Test Plan:
- Reset/idle: hold RESULT_IN=011, toggle vsync 20 frames, no request -> RESULT_VALID=0, BUSY=0, RESULT_OUT=000.
- Clean vote: request; RESULT_IN=011 in all frames -> VALID 3 cycles after the 12th frame tick (4 warmup + 8), RESULT_OUT=011; ACK high -> VALID drops; ACK/REQ low -> IDLE.
- Threshold/tie:
  - Window 4x010 + 4x101 -> tie to lower code, but count 4 < 5, so RESULT_OUT=000.
  - Window 5x101 + 3x010 -> RESULT_OUT=101.
- Timeout: TIMEOUT_CYC=100, never ACK -> VALID high exactly 100 cycles, then TIMEOUT=1, IDLE. The next request clears TIMEOUT.
- Abort and reset: drop REQ at frame 6 -> IDLE, no VALID. Separately, assert RESET_N=0 while in PRESENT -> all outputs take their reset values immediately, with no clock edge.
- Ignored request and edge case: pulse REQ low/high during COLLECT -> abort then restart from WARMUP; ACK arriving in the same cycle as timeout expiry -> RELEASE, TIMEOUT=0.

Source files
------------

// File: rtl/treasure_vote_ctrl.sv
// treasure_vote_ctrl
// Frame-level controller between the camera image processor and the Arduino.
// On an Arduino request it discards WARMUP_FRAMES settling frames and then
// collects one treasure code per VGA frame for NUM_FRAMES frames. It majority-votes
// the collected codes, with ties going to the lower code and CONF_MIN as the
// minimum winning count. The winner is presented over a REQ/VALID/ACK handshake
// with a TIMEOUT_CYC cycle timeout.
// Optional build macro: FAST_REPLY_EN. When it is defined, vote windows run
// continuously in the background while idle, so a request can be answered
// straight away from the most recent completed window.
module treasure_vote_ctrl #(
    parameter int NUM_FRAMES    = 8,
    parameter int CONF_MIN      = 5,
    parameter int WARMUP_FRAMES = 4,
    parameter int TIMEOUT_CYC   = 25000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       VGA_VSYNC_NEG,
    input  logic [2:0] RESULT_IN,
    input  logic       ARD_REQ,
    input  logic       ARD_ACK,
    output logic [2:0] RESULT_OUT,
    output logic       RESULT_VALID,
    output logic       BUSY,
    output logic       TIMEOUT
);
    typedef enum logic [2:0] {
        S_IDLE, S_WARMUP, S_COLLECT, S_DECIDE, S_PRESENT, S_RELEASE
    } state_t;

    localparam logic [7:0]  WARM_LAST = 8'(WARMUP_FRAMES - 1);
    localparam logic [7:0]  COLL_LAST = 8'(NUM_FRAMES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam bit          NO_WARMUP = (WARMUP_FRAMES == 0);

    state_t          state, next_state;
    logic            req_s1, req_s2, req_d;
    logic            ack_s1, ack_s2;
    logic            vs_r, vs_d, sample;
    logic            tick, req_evt;
    logic [7:0][3:0] hist;
    logic [7:0]      frame_cnt;
    logic [15:0]     tmo_cnt;
`ifdef FAST_REPLY_EN
    logic [2:0]      last_vote;
    logic            have_vote, bg_armed, bg_decide;
`endif

    // Most frequent code, lowest code on ties; weak majorities report "none".
    function automatic logic [2:0] vote_winner(input logic [7:0][3:0] h);
        logic [2:0] best;
        logic [3:0] best_cnt;
        best     = 3'd0;
        best_cnt = h[0];
        for (int i = 1; i < 8; i++) begin
            if (h[i] > best_cnt) begin
                best     = 3'(i);
                best_cnt = h[i];
            end
        end
        if (int'(best_cnt) < CONF_MIN) best = 3'd0;
        return best;
    endfunction

    // Frame tick fires on a registered vsync falling edge. The processor updates
    // RESULT on that same edge, so the code is taken one cycle later (sample).
    assign tick    = vs_d & ~vs_r;
    assign req_evt = req_s2 & ~req_d;

    assign RESULT_VALID = (state == S_PRESENT);
    assign BUSY         = (state != S_IDLE);

    // Two-flop synchronizers for the Arduino lines plus vsync/request edge history.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            req_d  <= 1'b0;
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            sample <= 1'b0;
        end else begin
            req_s1 <= ARD_REQ;
            req_s2 <= req_s1;
            req_d  <= req_s2;
            ack_s1 <= ARD_ACK;
            ack_s2 <= ack_s1;
            vs_r   <= VGA_VSYNC_NEG;
            vs_d   <= vs_r;
            sample <= tick;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (req_evt) begin
                    if (NO_WARMUP) next_state = S_COLLECT;
                    else           next_state = S_WARMUP;
`ifdef FAST_REPLY_EN
                    if (have_vote) next_state = S_PRESENT;
`endif
                end
            end
            S_WARMUP: begin
                if (!req_s2)                              next_state = S_IDLE;
                else if (sample && frame_cnt == WARM_LAST) next_state = S_COLLECT;
            end
            S_COLLECT: begin
                if (!req_s2)                              next_state = S_IDLE;
                else if (sample && frame_cnt == COLL_LAST) next_state = S_DECIDE;
            end
            S_DECIDE:  next_state = S_PRESENT;
            S_PRESENT: begin
                // ACK takes priority over a timeout expiring in the same cycle.
                if (ack_s2)                   next_state = S_RELEASE;
                else if (tmo_cnt == TMO_LAST) next_state = S_IDLE;
            end
            S_RELEASE: begin
                if (!ack_s2 && !req_s2) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Histogram, frame/timeout counters, presented result and sticky timeout flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hist       <= '0;
            frame_cnt  <= '0;
            tmo_cnt    <= '0;
            RESULT_OUT <= 3'd0;
            TIMEOUT    <= 1'b0;
`ifdef FAST_REPLY_EN
            last_vote  <= 3'd0;
            have_vote  <= 1'b0;
            bg_armed   <= NO_WARMUP;
            bg_decide  <= 1'b0;
`endif
        end else begin
            tmo_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (req_evt) begin
                        hist      <= '0;
                        frame_cnt <= '0;
                        TIMEOUT   <= 1'b0;
`ifdef FAST_REPLY_EN
                        bg_decide <= 1'b0;
                        if (have_vote) RESULT_OUT <= last_vote;
                    end else if (bg_decide) begin
                        last_vote <= vote_winner(hist);
                        have_vote <= 1'b1;
                        hist      <= '0;
                        bg_decide <= 1'b0;
                    end else if (sample) begin
                        if (!bg_armed) begin
                            if (frame_cnt == WARM_LAST) begin
                                frame_cnt <= '0;
                                bg_armed  <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end else begin
                            hist[RESULT_IN] <= hist[RESULT_IN] + 4'd1;
                            if (frame_cnt == COLL_LAST) begin
                                frame_cnt <= '0;
                                bg_decide <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end
`endif
                    end
                end
                S_WARMUP: begin
                    if (!req_s2) frame_cnt <= '0;
                    else if (sample)
                        frame_cnt <= (frame_cnt == WARM_LAST) ? 8'd0 : frame_cnt + 8'd1;
                end
                S_COLLECT: begin
                    if (!req_s2) begin
                        hist      <= '0;
                        frame_cnt <= '0;
                    end else if (sample) begin
                        hist[RESULT_IN] <= hist[RESULT_IN] + 4'd1;
                        frame_cnt       <= frame_cnt + 8'd1;
                    end
                end
                S_DECIDE: begin
                    RESULT_OUT <= vote_winner(hist);
                    hist       <= '0;
                    frame_cnt  <= '0;
                end
                S_PRESENT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (!ack_s2 && tmo_cnt == TMO_LAST) TIMEOUT <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_treasure_vote_ctrl.sv
// Self-checking bench for treasure_vote_ctrl (default build, TIMEOUT_CYC=100).
// A frame-level reference model predicts the outputs every cycle, and
// hand-computed literal checks pin the model at the key points.
module tb_treasure_vote_ctrl;
    localparam int NF   = 8;
    localparam int CMIN = 5;
    localparam int WARM = 4;
    localparam int TMO  = 100;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       VGA_VSYNC_NEG;
    logic [2:0] RESULT_IN;
    logic       ARD_REQ;
    logic       ARD_ACK;
    logic [2:0] RESULT_OUT;
    logic       RESULT_VALID;
    logic       BUSY;
    logic       TIMEOUT;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int valid_rise_cyc = 0;
    int valid_run = 0;
    int last_run = 0;
    logic prev_valid = 1'b0;

    treasure_vote_ctrl #(
        .NUM_FRAMES(NF), .CONF_MIN(CMIN), .WARMUP_FRAMES(WARM), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
        .RESULT_IN(RESULT_IN), .ARD_REQ(ARD_REQ), .ARD_ACK(ARD_ACK),
        .RESULT_OUT(RESULT_OUT), .RESULT_VALID(RESULT_VALID),
        .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_SKIP = 1, M_GATHER = 2, M_CHOOSE = 3, M_SHOW = 4, M_HOLD = 5;
    int         m_mode = M_IDLE;
    int         m_skipped = 0;
    int         m_shown = 0;
    logic [2:0] m_out = 3'd0;
    logic       m_tmo = 1'b0;
    logic [2:0] votes[$];
    logic [3:1] req_h = '0, ack_h = '0, vs_h = '0;

    function automatic logic [2:0] majority(input logic [2:0] v[$]);
        int tally[8];
        int best;
        foreach (tally[i]) tally[i] = 0;
        foreach (v[i]) tally[v[i]]++;
        best = 0;
        for (int c = 1; c < 8; c++) if (tally[c] > tally[best]) best = c;
        if (tally[best] < CMIN) return 3'd0;
        return 3'(best);
    endfunction

    // The controller sees the Arduino lines two clocks late, and it takes a code
    // one clock after it sees vsync fall, which is three clocks after the raw fall.
    initial forever begin
        logic req_lvl, req_old, ack_lvl, smp, new_req;
        @(posedge CLK or negedge RESET_N);
        if (!RESET_N) begin
            m_mode = M_IDLE; m_skipped = 0; m_shown = 0; m_out = 3'd0; m_tmo = 1'b0;
            votes.delete(); req_h = '0; ack_h = '0; vs_h = '0;
        end else begin
            req_lvl = req_h[2];
            req_old = req_h[3];
            ack_lvl = ack_h[2];
            smp     = vs_h[3] && !vs_h[2];
            new_req = req_lvl && !req_old;
            case (m_mode)
                M_IDLE: if (new_req) begin
                    votes.delete(); m_skipped = 0; m_tmo = 1'b0;
                    m_mode = (WARM == 0) ? M_GATHER : M_SKIP;
                end
                M_SKIP: begin
                    if (!req_lvl) m_mode = M_IDLE;
                    else if (smp) begin
                        m_skipped++;
                        if (m_skipped == WARM) m_mode = M_GATHER;
                    end
                end
                M_GATHER: begin
                    if (!req_lvl) begin m_mode = M_IDLE; votes.delete(); end
                    else if (smp) begin
                        votes.push_back(RESULT_IN);
                        if (votes.size() == NF) m_mode = M_CHOOSE;
                    end
                end
                M_CHOOSE: begin m_out = majority(votes); m_shown = 0; m_mode = M_SHOW; end
                M_SHOW: begin
                    m_shown++;
                    if (ack_lvl) m_mode = M_HOLD;
                    else if (m_shown == TMO) begin m_tmo = 1'b1; m_mode = M_IDLE; end
                end
                M_HOLD: if (!ack_lvl && !req_lvl) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
            req_h = {req_h[2], req_h[1], ARD_REQ};
            ack_h = {ack_h[2], ack_h[1], ARD_ACK};
            vs_h  = {vs_h[2], vs_h[1], VGA_VSYNC_NEG};
        end
    end

    // Per-cycle comparison against the model, plus VALID pulse measurement.
    initial forever begin
        @(negedge CLK);
        check("model_valid",   32'(RESULT_VALID), 32'(m_mode == M_SHOW));
        check("model_busy",    32'(BUSY),         32'(m_mode != M_IDLE));
        check("model_out",     32'(RESULT_OUT),   32'(m_out));
        check("model_timeout", 32'(TIMEOUT),      32'(m_tmo));
        if (RESULT_VALID) begin
            if (!prev_valid) valid_rise_cyc = cyc;
            valid_run++;
        end else begin
            if (prev_valid) last_run = valid_run;
            valid_run = 0;
        end
        prev_valid = RESULT_VALID;
    end

    // ---------------- stimulus ----------------
    task automatic frame(input logic [2:0] code);
        @(negedge CLK);
        VGA_VSYNC_NEG = 1'b0;
        RESULT_IN     = code;
        last_fall_cyc = cyc;
        repeat (3) @(negedge CLK);
        VGA_VSYNC_NEG = 1'b1;
        repeat (16) @(negedge CLK);
    endtask

    task automatic request();
        ARD_REQ = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic handshake(input string tag);
        ARD_ACK = 1'b1;
        repeat (5) @(negedge CLK);
        check({tag, "_valid_after_ack"}, 32'(RESULT_VALID), 32'd0);
        check({tag, "_busy_release"},    32'(BUSY),         32'd1);
        ARD_ACK = 1'b0;
        ARD_REQ = 1'b0;
        repeat (5) @(negedge CLK);
        check({tag, "_busy_idle"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic [2:0] seq [12];
        int target;
        RESET_N = 1'b0; VGA_VSYNC_NEG = 1'b1; ARD_REQ = 1'b0; ARD_ACK = 1'b0; RESULT_IN = 3'd0;
        repeat (3) @(negedge CLK);
        check("rst_out",     32'(RESULT_OUT),   32'd0);
        check("rst_valid",   32'(RESULT_VALID), 32'd0);
        check("rst_busy",    32'(BUSY),         32'd0);
        check("rst_timeout", 32'(TIMEOUT),      32'd0);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);

        // frames without a request never produce a result
        for (int i = 0; i < 20; i++) frame(3'b011);
        check("idle_valid", 32'(RESULT_VALID), 32'd0);
        check("idle_busy",  32'(BUSY),         32'd0);
        check("idle_out",   32'(RESULT_OUT),   32'd0);

        // clean vote
        request();
        for (int i = 0; i < 12; i++) frame(3'b011);
        check("clean_out",     32'(RESULT_OUT),   32'd3);
        check("clean_valid",   32'(RESULT_VALID), 32'd1);
        check("clean_latency", 32'(valid_rise_cyc - last_fall_cyc), 32'd4);
        handshake("clean");
        check("clean_hold", 32'(RESULT_OUT), 32'd3);

        // 4x010 + 4x101: tie to 010 but only 4 votes -> 000 (warmup 101s discarded)
        seq = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5};
        request();
        foreach (seq[i]) frame(seq[i]);
        check("tie_out",   32'(RESULT_OUT),   32'd0);
        check("tie_valid", 32'(RESULT_VALID), 32'd1);
        handshake("tie");

        // 5x101 + 3x010 -> 101 (warmup 010s discarded)
        seq = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd5, 3'd5};
        request();
        foreach (seq[i]) frame(seq[i]);
        check("maj_out", 32'(RESULT_OUT), 32'd5);
        handshake("maj");

        // timeout: no ACK
        request();
        for (int i = 0; i < 12; i++) frame(3'b110);
        repeat (100) @(negedge CLK);
        check("tmo_flag",  32'(TIMEOUT),      32'd1);
        check("tmo_valid", 32'(RESULT_VALID), 32'd0);
        check("tmo_busy",  32'(BUSY),         32'd0);
        check("tmo_len",   32'(last_run),     32'd100);
        check("tmo_out",   32'(RESULT_OUT),   32'd6);
        ARD_REQ = 1'b0;
        repeat (4) @(negedge CLK);
        request();
        check("tmo_cleared", 32'(TIMEOUT), 32'd0);
        check("tmo_rebusy",  32'(BUSY),    32'd1);

        // abort at frame 6
        for (int i = 0; i < 6; i++) frame(3'b001);
        ARD_REQ = 1'b0;
        repeat (4) @(negedge CLK);
        check("abort_busy",  32'(BUSY),         32'd0);
        check("abort_valid", 32'(RESULT_VALID), 32'd0);
        check("abort_out",   32'(RESULT_OUT),   32'd6);
        for (int i = 0; i < 3; i++) frame(3'b001);
        check("abort_quiet", 32'(RESULT_VALID), 32'd0);

        // REQ low pulse during COLLECT: abort then restart from warmup
        request();
        for (int i = 0; i < 6; i++) frame(3'b100);
        ARD_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        check("pulse_abort", 32'(BUSY), 32'd0);
        request();
        check("pulse_restart", 32'(BUSY), 32'd1);
        for (int i = 0; i < 12; i++) frame(3'b001);
        check("pulse_out",   32'(RESULT_OUT),   32'd1);
        check("pulse_valid", 32'(RESULT_VALID), 32'd1);

        // ACK seen by the controller exactly in the timeout-expiry cycle
        target = valid_rise_cyc + 97;
        for (int i = 0; i < 200 && cyc != target; i++) @(negedge CLK);
        check("edge_align", 32'(cyc), 32'(target));
        ARD_ACK = 1'b1;
        repeat (5) @(negedge CLK);
        check("edge_valid",   32'(RESULT_VALID), 32'd0);
        check("edge_busy",    32'(BUSY),         32'd1);
        check("edge_timeout", 32'(TIMEOUT),      32'd0);
        check("edge_len",     32'(last_run),     32'd100);
        ARD_ACK = 1'b0;
        ARD_REQ = 1'b0;
        repeat (5) @(negedge CLK);
        check("edge_idle", 32'(BUSY), 32'd0);

        // code 111 counts like any other; async reset while presenting
        request();
        for (int i = 0; i < 12; i++) frame(3'b111);
        check("c7_out",   32'(RESULT_OUT),   32'd7);
        check("c7_valid", 32'(RESULT_VALID), 32'd1);
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_out",     32'(RESULT_OUT),   32'd0);
        check("arst_valid",   32'(RESULT_VALID), 32'd0);
        check("arst_busy",    32'(BUSY),         32'd0);
        check("arst_timeout", 32'(TIMEOUT),      32'd0);
        @(negedge CLK);
        ARD_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("final_busy", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
